hex_keypad_entry: RTL and testbench

Input-side counterpart to the 8-digit hex display controller: scans a 4x4 hex keypad (PmodKYPD-style, active-low columns and rows) and debounces it. Each accepted key press is shifted as one nibble into a 128-bit entry register. The register feeds the AES key/plaintext path and is echoed back on the seven-segment display. The block produces exactly one key event per physical press, robust to contact bounce and multi-key presses.

---
 rtl/aes_ui_pkg.sv | 27 ++
 rtl/keypad_col_scanner.sv | 84 ++++++++
 rtl/hex_keypad_entry.sv | 145 ++++++++++++++
 tb/tb_hex_keypad_entry.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/aes_ui_pkg.sv
// Types and constants shared by the keypad entry block and its column scanner.
package aes_ui_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_res_e;

  localparam int NIBBLES = 32;

  // Indexed by row*4 + col; entry [0] is row 0 / column 0.
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

endpackage

// File: rtl/keypad_col_scanner.sv
// Drives the keypad columns, synchronizes the rows and classifies each
// four-column frame as no key, one key (with its code) or several keys.
module keypad_col_scanner
  import aes_ui_pkg::*;
#(
  parameter int SCAN_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic       frame_done_o,
  output logic [1:0] frame_res_o,
  output logic [3:0] frame_code_o
);

  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);

  logic [CW-1:0] scan_q, scan_d;
  logic [1:0]    cidx_q, cidx_d;
  logic [3:0]    sync1_q, sync2_q;
  logic [11:0]   hits_q, hits_d;
  logic          sample;
  logic [15:0]   all_hits;
  logic [4:0]    nhits;
  logic [3:0]    code;

  assign sample = (scan_q == SCAN_LAST);

  always_comb begin
    scan_d = scan_q + CW'(1);
    cidx_d = cidx_q;
    hits_d = hits_q;
    if (sample) begin
      scan_d = '0;
      cidx_d = cidx_q + 2'd1;
      case (cidx_q)
        2'd0:    hits_d[3:0]  = ~sync2_q;
        2'd1:    hits_d[7:4]  = ~sync2_q;
        2'd2:    hits_d[11:8] = ~sync2_q;
        default: hits_d       = hits_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q  <= '0;
      cidx_q  <= '0;
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      hits_q  <= '0;
    end else begin
      scan_q  <= scan_d;
      cidx_q  <= cidx_d;
      sync1_q <= row_i;
      sync2_q <= sync1_q;
      hits_q  <= hits_d;
    end
  end

  // Bit c*4+r of all_hits is key (row r, column c); column 3 comes straight
  // from the synchronizer so the result is ready on its own sample edge.
  assign all_hits = {~sync2_q, hits_q};

  always_comb begin
    nhits = '0;
    code  = '0;
    for (int i = 0; i < 16; i++) begin
      if (all_hits[i]) begin
        nhits = nhits + 5'd1;
        code  = KEYMAP[(i % 4) * 4 + (i / 4)];
      end
    end
  end

  assign col_o        = ~(4'b0001 << cidx_q);
  assign frame_done_o = sample && (cidx_q == 2'd3);
  assign frame_code_o = code;
  assign frame_res_o  = (nhits == 5'd0) ? FR_NONE :
                        (nhits == 5'd1) ? FR_SINGLE : FR_MULTI;

endmodule

// File: rtl/hex_keypad_entry.sv
// Debounced hex keypad entry: one nibble per press shifted into a 128-bit
// register with a saturating nibble count.
module hex_keypad_entry
  import aes_ui_pkg::*;
#(
  parameter int SCAN_CYCLES     = 100000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   row,
  input  logic         clear,
  output logic [3:0]   col,
  output logic [127:0] data,
  output logic         key_valid,
  output logic [3:0]   key_code,
  output logic [5:0]   nibble_count,
  output logic         full
);

  localparam int DCW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DCW-1:0] DF_CNT = DCW'(DEBOUNCE_FRAMES);

  logic       frame_done;
  logic [1:0] frame_res_w;
  frame_res_e frame_res;
  logic [3:0] frame_code;

  kp_state_e      state_q, state_d;
  logic [3:0]     cand_q, cand_d;
  logic [DCW-1:0] cnt_q, cnt_d, cnt_inc;
  logic           accept;

  logic [127:0] data_q;
  logic [5:0]   count_q;
  logic         key_valid_q;
  logic [3:0]   key_code_q;

  keypad_col_scanner #(
    .SCAN_CYCLES(SCAN_CYCLES)
  ) u_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .row_i       (row),
    .col_o       (col),
    .frame_done_o(frame_done),
    .frame_res_o (frame_res_w),
    .frame_code_o(frame_code)
  );

  assign frame_res = frame_res_e'(frame_res_w);
  assign cnt_inc   = cnt_q + DCW'(1);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (frame_done) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_res == FR_SINGLE) begin
            cand_d = frame_code;
            cnt_d  = DCW'(1);
            if (DEBOUNCE_FRAMES == 1) begin
              accept  = 1'b1;
              state_d = ST_PRESSED;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (frame_res == FR_SINGLE && frame_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DF_CNT) begin
              accept  = 1'b1;
              state_d = ST_PRESSED;
            end
          end else if (frame_res == FR_SINGLE) begin
            cand_d = frame_code;
            cnt_d  = DCW'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (frame_res == FR_NONE) begin
            cnt_d   = DCW'(1);
            state_d = (DEBOUNCE_FRAMES == 1) ? ST_IDLE : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (frame_res == FR_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DF_CNT) state_d = ST_IDLE;
          end else begin
            state_d = ST_PRESSED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // A clear on the accept edge swallows the key: the FSM still moves to
  // PRESSED above, but nothing is recorded or announced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      count_q     <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      key_valid_q <= accept && !clear;
      if (clear) begin
        data_q  <= '0;
        count_q <= '0;
      end else if (accept) begin
        data_q     <= {data_q[123:0], cand_d};
        key_code_q <= cand_d;
        if (count_q != 6'(NIBBLES)) count_q <= count_q + 6'd1;
      end
    end
  end

  assign data         = data_q;
  assign nibble_count = count_q;
  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign full         = (count_q == 6'(NIBBLES));

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry with a 4x4 keypad model (8-cycle
// column periods, 3-frame debounce, 32-cycle frames).
module tb_hex_keypad_entry;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic [3:0]   row;
  logic [3:0]   col;
  logic [127:0] data;
  logic         key_valid;
  logic [3:0]   key_code;
  logic [5:0]   nibble_count;
  logic         full;

  logic [15:0]  pressed = '0;
  logic [3:0]   idx_of [16];
  int nchk = 0;
  int nerr = 0;
  int ecnt;
  int vld_total = 0;
  int last_vld_edge = -1;
  int s;
  int e0;

  hex_keypad_entry #(
    .SCAN_CYCLES    (8),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .clear       (clear),
    .col         (col),
    .data        (data),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .nibble_count(nibble_count),
    .full        (full)
  );

  always #5 clk = ~clk;

  // pressed bit r*4+c is the switch at row r, column c
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r*4 +: 4] & ~col);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      vld_total     <= vld_total + 1;
      last_vld_edge <= ecnt;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * 32) @(negedge clk);
  endtask

  task automatic align();
    for (int i = 0; i < 32 && (ecnt % 32) != 0; i++) @(negedge clk);
  endtask

  initial begin
    idx_of[0]  = 4'd12; idx_of[1]  = 4'd0;  idx_of[2]  = 4'd1;  idx_of[3]  = 4'd2;
    idx_of[4]  = 4'd4;  idx_of[5]  = 4'd5;  idx_of[6]  = 4'd6;  idx_of[7]  = 4'd8;
    idx_of[8]  = 4'd9;  idx_of[9]  = 4'd10; idx_of[10] = 4'd3;  idx_of[11] = 4'd7;
    idx_of[12] = 4'd11; idx_of[13] = 4'd15; idx_of[14] = 4'd14; idx_of[15] = 4'd13;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_col", col, 4'b1110);
    chk("rst_data", data, 0);
    chk("rst_count", nibble_count, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_code", key_code, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    chk("col_hold", col, 4'b1110);
    @(negedge clk);
    chk("col_step", col, 4'b1101);

    // single press of key 5
    align();
    e0 = ecnt;
    s = vld_total;
    pressed = 16'b1 << 5;
    frames(10);
    chk("k5_edge", 128'(last_vld_edge), 128'(e0 + 96));
    pressed = '0;
    frames(5);
    chk("k5_pulses", 128'(vld_total - s), 1);
    chk("k5_code", key_code, 4'h5);
    chk("k5_data", data, 128'h5);
    chk("k5_count", nibble_count, 1);

    // bouncing key A
    s = vld_total;
    pressed = 16'b1 << 3; frames(2);
    pressed = '0;         frames(1);
    pressed = 16'b1 << 3; frames(2);
    pressed = '0;         frames(1);
    chk("bnc_none", 128'(vld_total - s), 0);
    e0 = ecnt;
    pressed = 16'b1 << 3;
    frames(3);
    pressed = '0;
    frames(4);
    chk("bnc_pulses", 128'(vld_total - s), 1);
    chk("bnc_edge", 128'(last_vld_edge), 128'(e0 + 96));
    chk("bnc_code", key_code, 4'hA);
    chk("bnc_data", data, 128'h5A);
    chk("bnc_count", nibble_count, 2);

    // keys 1 and 2 together, then 1 alone
    s = vld_total;
    pressed = 16'b11;
    frames(6);
    chk("multi_none", 128'(vld_total - s), 0);
    e0 = ecnt;
    pressed = 16'b1;
    frames(3);
    pressed = '0;
    frames(4);
    chk("multi_pulses", 128'(vld_total - s), 1);
    chk("multi_edge", 128'(last_vld_edge), 128'(e0 + 96));
    chk("multi_code", key_code, 4'h1);
    chk("multi_data", data, 128'h5A1);
    chk("multi_count", nibble_count, 3);

    // clear on the accept edge of key 7
    s = vld_total;
    pressed = 16'b1 << 8;
    repeat (95) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_valid", key_valid, 0);
    chk("clr_data", data, 0);
    chk("clr_count", nibble_count, 0);
    chk("clr_code", key_code, 4'h1);
    frames(5);
    chk("clr_hold", 128'(vld_total - s), 0);
    pressed = '0;
    frames(4);

    // 33 keys cycling 0..F
    s = vld_total;
    for (int i = 0; i < 33; i++) begin
      pressed = 16'b1 << idx_of[i % 16];
      frames(3);
      pressed = '0;
      frames(3);
    end
    chk("ovf_pulses", 128'(vld_total - s), 33);
    chk("ovf_count", nibble_count, 32);
    chk("ovf_full", full, 1);
    chk("ovf_top", data[127:124], 4'h1);
    chk("ovf_low", data[3:0], 4'h0);
    chk("ovf_data", data, 128'h123456789ABCDEF0123456789ABCDEF0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
